execute_memory_latch: RTL and testbench

//  Consumer side of the execute stage: owns the architectural condition-code register (CC)
//  and the E->M pipeline register of the Y86-64 pipeline. Commits new_cc/set_cc, nulls a

---
 rtl/execute_memory_latch.sv | 115 +++++++++++
 tb/tb_execute_memory_latch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_memory_latch.sv
// Execute-to-memory boundary of the Y86-64 pipeline.
// Holds the architectural condition codes and the E->M pipeline register,
// nulls the destination of a cmovXX whose condition failed, and freezes the
// condition codes once a faulting instruction has reached the memory stage.
module execute_memory_latch #(
   parameter int unsigned WIDTH    = 64,
   parameter logic [2:0]  CC_RESET = 3'b001
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [3:0]       e_icode,
   input  logic [3:0]       e_ifun,
   input  logic [2:0]       e_stat,
   input  logic [WIDTH-1:0] e_valE,
   input  logic [WIDTH-1:0] e_valA,
   input  logic [3:0]       e_dstE,
   input  logic [3:0]       e_dstM,
   input  logic             e_Cnd,
   input  logic [2:0]       new_cc,
   input  logic             set_cc,
   input  logic [2:0]       W_stat,
   input  logic             M_stall,
   input  logic             M_bubble,
   output logic [2:0]       cc,
   output logic [3:0]       M_icode,
   output logic [3:0]       M_ifun,
   output logic [2:0]       M_stat,
   output logic             M_Cnd,
   output logic [WIDTH-1:0] M_valE,
   output logic [WIDTH-1:0] M_valA,
   output logic [3:0]       M_dstE,
   output logic [3:0]       M_dstM,
   output logic             mispredict,
   output logic             exc_lock
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOV   = 4'h2;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] REG_NONE = 4'hF;

   logic       cc_write;
   logic       load_e;
   logic       load_fault;
   logic [3:0] dstE_next;

   // Decide whether this edge commits new condition codes, whether E is
   // being copied into M, and what destination a cmov really writes.
   // Only an OPQ in a fault-free pipeline may touch CC; a stall on M means
   // the OPQ will be replayed, so it must not commit yet.
   always_comb begin
      cc_write   = set_cc && (e_icode == I_OPQ) && !M_stall && !exc_lock &&
                   (e_stat == STAT_AOK) && (M_stat == STAT_AOK) &&
                   (W_stat == STAT_AOK);
      load_e     = !M_bubble && !M_stall;
      load_fault = load_e && (e_stat != STAT_AOK);
      dstE_next  = ((e_icode == I_CMOV) && !e_Cnd) ? REG_NONE : e_dstE;
   end

   // Architectural condition-code register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cc <= CC_RESET;
      end else if (cc_write) begin
         cc <= new_cc;
      end
   end

   // E->M pipeline register: a bubble wins over a stall, which wins over a load.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         M_icode <= I_NOP;
         M_ifun  <= 4'h0;
         M_stat  <= STAT_AOK;
         M_Cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= REG_NONE;
         M_dstM  <= REG_NONE;
      end else if (M_bubble) begin
         M_icode <= I_NOP;
         M_ifun  <= 4'h0;
         M_stat  <= STAT_AOK;
         M_Cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= REG_NONE;
         M_dstM  <= REG_NONE;
      end else if (!M_stall) begin
         M_icode <= e_icode;
         M_ifun  <= e_ifun;
         M_stat  <= e_stat;
         M_Cnd   <= e_Cnd;
         M_valE  <= e_valE;
         M_valA  <= e_valA;
         M_dstE  <= dstE_next;
         M_dstM  <= e_dstM;
      end
   end

   // Sticky lock raised when a faulting status first enters M; only reset clears it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exc_lock <= 1'b0;
      end else if (load_fault) begin
         exc_lock <= 1'b1;
      end
   end

   // A not-taken jump sitting in M means fetch guessed wrong.
   assign mispredict = (M_icode == I_JXX) && !M_Cnd;

endmodule

// File: tb/tb_execute_memory_latch.sv
// Directed, self-checking bench for execute_memory_latch.
// Each step pushes the expected M-stage and CC state onto a scoreboard
// before the clock edge and pops/compares it once the edge has passed.
module tb_execute_memory_latch;

   logic        clock;
   logic        reset_n;
   logic [3:0]  e_icode;
   logic [3:0]  e_ifun;
   logic [2:0]  e_stat;
   logic [63:0] e_valE;
   logic [63:0] e_valA;
   logic [3:0]  e_dstE;
   logic [3:0]  e_dstM;
   logic        e_Cnd;
   logic [2:0]  new_cc;
   logic        set_cc;
   logic [2:0]  W_stat;
   logic        M_stall;
   logic        M_bubble;
   logic [2:0]  cc;
   logic [3:0]  M_icode;
   logic [3:0]  M_ifun;
   logic [2:0]  M_stat;
   logic        M_Cnd;
   logic [63:0] M_valE;
   logic [63:0] M_valA;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;
   logic        mispredict;
   logic        exc_lock;

   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [2:0]  stat;
      logic        cnd;
      logic [63:0] valE;
      logic [63:0] valA;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
      logic [2:0]  cc;
      logic        lock;
   } exp_t;

   exp_t sb[$];
   exp_t m_model;
   int   checks = 0;
   int   errors = 0;

   execute_memory_latch #(.WIDTH(64), .CC_RESET(3'b001)) dut (
      .clock(clock), .reset_n(reset_n),
      .e_icode(e_icode), .e_ifun(e_ifun), .e_stat(e_stat),
      .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
      .e_Cnd(e_Cnd), .new_cc(new_cc), .set_cc(set_cc), .W_stat(W_stat),
      .M_stall(M_stall), .M_bubble(M_bubble), .cc(cc),
      .M_icode(M_icode), .M_ifun(M_ifun), .M_stat(M_stat), .M_Cnd(M_Cnd),
      .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
      .mispredict(mispredict), .exc_lock(exc_lock)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic exp_t nop_state();
      exp_t n;
      n.icode = 4'h1; n.ifun = 4'h0; n.stat = 3'd1; n.cnd = 1'b0;
      n.valE = 64'h0; n.valA = 64'h0; n.dstE = 4'hF; n.dstM = 4'hF;
      n.cc = 3'b001; n.lock = 1'b0;
      return n;
   endfunction

   task automatic check_field(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_e(input logic [3:0] icode, input logic [3:0] ifun, input logic [2:0] stat,
                          input logic [63:0] valE, input logic [63:0] valA,
                          input logic [3:0] dstE, input logic [3:0] dstM, input logic cnd);
      e_icode = icode; e_ifun = ifun; e_stat = stat; e_valE = valE;
      e_valA = valA; e_dstE = dstE; e_dstM = dstM; e_Cnd = cnd;
   endtask

   task automatic check_output();
      exp_t got;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL scoreboard: observed empty queue expected entry");
      end else begin
         got = sb.pop_front();
         check_field("M_icode", 64'(M_icode), 64'(got.icode));
         check_field("M_ifun", 64'(M_ifun), 64'(got.ifun));
         check_field("M_stat", 64'(M_stat), 64'(got.stat));
         check_field("M_Cnd", 64'(M_Cnd), 64'(got.cnd));
         check_field("M_valE", M_valE, got.valE);
         check_field("M_valA", M_valA, got.valA);
         check_field("M_dstE", 64'(M_dstE), 64'(got.dstE));
         check_field("M_dstM", 64'(M_dstM), 64'(got.dstM));
         check_field("cc", 64'(cc), 64'(got.cc));
         check_field("exc_lock", 64'(exc_lock), 64'(got.lock));
         check_field("mispredict", 64'(mispredict),
                     64'((got.icode == 4'h7) && !got.cnd));
      end
   endtask

   // Predict next M contents from the driven controls, push, clock, compare.
   task automatic apply_stimulus(input logic [2:0] exp_cc, input logic exp_lock);
      exp_t nxt;
      if (M_bubble) begin
         nxt = nop_state();
      end else if (M_stall) begin
         nxt = m_model;
      end else begin
         nxt.icode = e_icode; nxt.ifun = e_ifun; nxt.stat = e_stat; nxt.cnd = e_Cnd;
         nxt.valE = e_valE; nxt.valA = e_valA; nxt.dstM = e_dstM;
         nxt.dstE = (e_icode == 4'h2 && !e_Cnd) ? 4'hF : e_dstE;
      end
      nxt.cc = exp_cc;
      nxt.lock = exp_lock;
      m_model = nxt;
      sb.push_back(nxt);
      @(posedge clock);
      #1;
      check_output();
   endtask

   task automatic check_reset(input string tag);
      check_field({tag, "_cc"}, 64'(cc), 64'(3'b001));
      check_field({tag, "_icode"}, 64'(M_icode), 64'(4'h1));
      check_field({tag, "_stat"}, 64'(M_stat), 64'(3'd1));
      check_field({tag, "_dstE"}, 64'(M_dstE), 64'(4'hF));
      check_field({tag, "_dstM"}, 64'(M_dstM), 64'(4'hF));
      check_field({tag, "_valE"}, M_valE, 64'h0);
      check_field({tag, "_mispredict"}, 64'(mispredict), 64'(1'b0));
      check_field({tag, "_lock"}, 64'(exc_lock), 64'(1'b0));
      m_model = nop_state();
   endtask

   // Linear sequence of directed steps.
   initial begin
      reset_n = 1'b0;
      drive_e(4'h1, 4'h0, 3'd1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0);
      new_cc = 3'b000; set_cc = 1'b0; W_stat = 3'd1;
      M_stall = 1'b0; M_bubble = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check_reset("reset");

      // OPQ commits CC one edge later; valE passes through.
      drive_e(4'h6, 4'h0, 3'd1, 64'h1234_5678_9ABC_DEF0, 64'h5, 4'h3, 4'hF, 1'b1);
      set_cc = 1'b1; new_cc = 3'b010;
      apply_stimulus(3'b010, 1'b0);
      set_cc = 1'b0;

      // cmov nulling and pass-through.
      drive_e(4'h2, 4'h3, 3'd1, 64'hAA, 64'hBB, 4'h3, 4'hF, 1'b0);
      apply_stimulus(3'b010, 1'b0);
      check_field("cmov_fail_dstE", 64'(M_dstE), 64'(4'hF));
      drive_e(4'h2, 4'h3, 3'd1, 64'hAA, 64'hBB, 4'h3, 4'hF, 1'b1);
      apply_stimulus(3'b010, 1'b0);
      check_field("cmov_take_dstE", 64'(M_dstE), 64'(4'h3));
      // rrmovq with set_cc asserted: not an OPQ, so CC stays.
      drive_e(4'h2, 4'h0, 3'd1, 64'h77, 64'h66, 4'h5, 4'hF, 1'b1);
      set_cc = 1'b1; new_cc = 3'b111;
      apply_stimulus(3'b010, 1'b0);
      set_cc = 1'b0;

      // Not-taken jump raises mispredict, then a bubble clears it while an OPQ
      // in E still commits CC.
      drive_e(4'h7, 4'h2, 3'd1, 64'h1000, 64'h40, 4'hF, 4'hF, 1'b0);
      apply_stimulus(3'b010, 1'b0);
      check_field("jxx_mispredict", 64'(mispredict), 64'(1'b1));
      check_field("jxx_valA", M_valA, 64'h40);
      drive_e(4'h6, 4'h1, 3'd1, 64'h9, 64'h8, 4'h2, 4'hF, 1'b1);
      M_bubble = 1'b1; set_cc = 1'b1; new_cc = 3'b011;
      apply_stimulus(3'b011, 1'b0);
      check_field("bubble_icode", 64'(M_icode), 64'(4'h1));
      check_field("bubble_mispredict", 64'(mispredict), 64'(1'b0));
      M_bubble = 1'b0;

      // Writeback halt alone blocks the CC write.
      W_stat = 3'd2; new_cc = 3'b100;
      apply_stimulus(3'b011, 1'b0);
      W_stat = 3'd1; set_cc = 1'b0;

      // Stall holds M and blocks CC while E toggles; stall+bubble gives a bubble.
      drive_e(4'h5, 4'h0, 3'd1, 64'h100, 64'h200, 4'hF, 4'h7, 1'b1);
      apply_stimulus(3'b011, 1'b0);
      M_stall = 1'b1; set_cc = 1'b1; new_cc = 3'b110;
      for (int i = 0; i < 3; i++) begin
         drive_e(4'h6, 4'(i), 3'd1, 64'(i * 17 + 3), 64'(i * 5 + 1), 4'(i), 4'hF, i[0]);
         apply_stimulus(3'b011, 1'b0);
      end
      check_field("stall_dstM", 64'(M_dstM), 64'(4'h7));
      M_bubble = 1'b1;
      apply_stimulus(3'b011, 1'b0);
      M_bubble = 1'b0; M_stall = 1'b0;

      // Faulting instruction enters M: lock rises, CC frozen afterwards.
      drive_e(4'h6, 4'h0, 3'd3, 64'h55, 64'h44, 4'h1, 4'hF, 1'b1);
      new_cc = 3'b101;
      apply_stimulus(3'b011, 1'b1);
      drive_e(4'h6, 4'h0, 3'd1, 64'h66, 64'h33, 4'h1, 4'hF, 1'b1);
      new_cc = 3'b100;
      apply_stimulus(3'b011, 1'b1);
      apply_stimulus(3'b011, 1'b1);
      M_bubble = 1'b1;
      apply_stimulus(3'b011, 1'b1);
      M_bubble = 1'b0;

      // Reset asserted between edges takes effect immediately.
      reset_n = 1'b0;
      #2;
      check_reset("async_reset");
      @(negedge clock);
      reset_n = 1'b1;
      new_cc = 3'b110;
      apply_stimulus(3'b110, 1'b0);
      set_cc = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: observed no finish expected finish");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
